mem_access_unit: RTL and testbench

- Initiator-side load/store sequencer between the multi-cycle core datapath and the unified word-addressed instruction/data memory.
- Accepts one byte, halfword or word access at a time and drives the memory's `we`/`a`/`wd` port, reading its combinational `rd`.
- Performs byte-lane alignment with sign or zero extension on loads.
- Memory writes whole words only, so sub-word stores use read-modify-write; misaligned accesses are rejected.

---
 rtl/mem_access_pkg.sv | 32 +++
 rtl/mau_lane_align.sv | 61 ++++++
 rtl/mem_access_unit.sv | 160 ++++++++++++++++
 tb/tb_mem_access_unit.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_access_pkg.sv
// rtl/mem_access_pkg.sv - shared types and alignment rule for the memory access unit
package mem_access_pkg;

    localparam int MAU_XLEN = 32;

    typedef enum logic [1:0] {
        BYTE    = 2'b00,
        HALF    = 2'b01,
        WORD    = 2'b10,
        ILLEGAL = 2'b11
    } mem_size_e;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        READ  = 2'b01,
        WRITE = 2'b10,
        RESP  = 2'b11
    } mau_state_e;

    // Illegal sizes count as faults so both reject paths share one check.
    function automatic logic access_fault(input mem_size_e size, input logic [1:0] lane);
        logic fault;
        case (size)
            BYTE:    fault = 1'b0;
            HALF:    fault = lane[0];
            WORD:    fault = |lane;
            default: fault = 1'b1;
        endcase
        return fault;
    endfunction

endpackage

// File: rtl/mau_lane_align.sv
// rtl/mau_lane_align.sv - byte-lane extract/extend for loads and lane merge for stores
module mau_lane_align
    import mem_access_pkg::*;
#(
    parameter int XLEN = MAU_XLEN
) (
    input  mem_size_e        size_i,
    input  logic             unsigned_i,
    input  logic [1:0]       lane_i,
    input  logic [XLEN-1:0]  rd_word_i,
    input  logic [XLEN-1:0]  wdata_i,
    output logic [XLEN-1:0]  load_data_o,
    output logic [XLEN-1:0]  merged_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = rd_word_i[7:0];
        case (lane_i)
            2'd0:    byte_sel = rd_word_i[7:0];
            2'd1:    byte_sel = rd_word_i[15:8];
            2'd2:    byte_sel = rd_word_i[23:16];
            default: byte_sel = rd_word_i[31:24];
        endcase
        half_sel = lane_i[1] ? rd_word_i[31:16] : rd_word_i[15:0];
    end

    always_comb begin
        load_data_o = rd_word_i;
        case (size_i)
            BYTE:    load_data_o = {{(XLEN-8){~unsigned_i & byte_sel[7]}}, byte_sel};
            HALF:    load_data_o = {{(XLEN-16){~unsigned_i & half_sel[15]}}, half_sel};
            default: load_data_o = rd_word_i;
        endcase
    end

    always_comb begin
        merged_o = rd_word_i;
        case (size_i)
            BYTE: begin
                case (lane_i)
                    2'd0:    merged_o[7:0]   = wdata_i[7:0];
                    2'd1:    merged_o[15:8]  = wdata_i[7:0];
                    2'd2:    merged_o[23:16] = wdata_i[7:0];
                    default: merged_o[31:24] = wdata_i[7:0];
                endcase
            end
            HALF: begin
                if (lane_i[1]) begin
                    merged_o[31:16] = wdata_i[15:0];
                end else begin
                    merged_o[15:0] = wdata_i[15:0];
                end
            end
            default: merged_o = wdata_i;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - load/store sequencer with read-modify-write for sub-word stores
module mem_access_unit
    import mem_access_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_write,
    input  logic [1:0]      req_size,
    input  logic            req_unsigned,
    input  logic [XLEN-1:0] req_addr,
    input  logic [XLEN-1:0] req_wdata,
    output logic            rsp_valid,
    output logic            rsp_err,
    output logic [XLEN-1:0] rsp_rdata,
    output logic            mem_we,
    output logic [XLEN-1:0] mem_a,
    output logic [XLEN-1:0] mem_wd,
    input  logic [XLEN-1:0] mem_rd
);

    mau_state_e      state_q, state_d;
    logic            write_q, write_d;
    mem_size_e       size_q, size_d;
    logic            uns_q, uns_d;
    logic [XLEN-1:0] addr_q, addr_d;
    logic [XLEN-1:0] wdata_q, wdata_d;
    logic [XLEN-1:0] wr_word_q, wr_word_d;
    logic [XLEN-1:0] rsp_rdata_q, rsp_rdata_d;
    logic            rsp_err_q, rsp_err_d;

    mem_size_e       req_size_e;
    logic            req_fault;
    logic            accept;
    logic [XLEN-1:0] load_data;
    logic [XLEN-1:0] merged_word;

    assign req_size_e = mem_size_e'(req_size);
    assign req_fault  = access_fault(req_size_e, req_addr[1:0]);
    assign accept     = req_valid && req_ready;

    mau_lane_align #(
        .XLEN(XLEN)
    ) u_lane_align (
        .size_i      (size_q),
        .unsigned_i  (uns_q),
        .lane_i      (addr_q[1:0]),
        .rd_word_i   (mem_rd),
        .wdata_i     (wdata_q),
        .load_data_o (load_data),
        .merged_o    (merged_word)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Sub-word stores read first even though they are stores: the merge needs the old word.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    if (req_fault) begin
                        state_d = RESP;
                    end else if (!req_write || req_size_e != WORD) begin
                        state_d = READ;
                    end else begin
                        state_d = WRITE;
                    end
                end
            end
            READ:    state_d = write_q ? WRITE : RESP;
            WRITE:   state_d = RESP;
            default: state_d = IDLE;
        endcase
    end

    // mem_we decodes the state register directly so reset kills it without waiting for a clock.
    always_comb begin
        req_ready = (state_q == IDLE);
        mem_we    = (state_q == WRITE);
        rsp_valid = (state_q == RESP);
    end

    always_comb begin
        write_d     = write_q;
        size_d      = size_q;
        uns_d       = uns_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        wr_word_d   = wr_word_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    write_d   = req_write;
                    size_d    = req_size_e;
                    uns_d     = req_unsigned;
                    addr_d    = req_addr;
                    wdata_d   = req_wdata;
                    wr_word_d = req_wdata;
                    if (req_fault) begin
                        rsp_rdata_d = '0;
                        rsp_err_d   = 1'b1;
                    end
                end
            end
            READ: begin
                if (write_q) begin
                    wr_word_d = merged_word;
                end else begin
                    rsp_rdata_d = load_data;
                    rsp_err_d   = 1'b0;
                end
            end
            WRITE: begin
                rsp_rdata_d = '0;
                rsp_err_d   = 1'b0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            write_q     <= 1'b0;
            size_q      <= BYTE;
            uns_q       <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            wr_word_q   <= '0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            write_q     <= write_d;
            size_q      <= size_d;
            uns_q       <= uns_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            wr_word_q   <= wr_word_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign mem_a     = {addr_q[XLEN-1:2], 2'b00};
    assign mem_wd    = wr_word_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - self-checking bench for mem_access_unit
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_unsigned = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        rsp_valid;
    logic        rsp_err;
    logic [31:0] rsp_rdata;
    logic        mem_we;
    logic [31:0] mem_a;
    logic [31:0] mem_wd;
    logic [31:0] mem_rd;

    always #5 clk = ~clk;

    mem_access_unit #(.XLEN(32)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_write    (req_write),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_err      (rsp_err),
        .rsp_rdata    (rsp_rdata),
        .mem_we       (mem_we),
        .mem_a        (mem_a),
        .mem_wd       (mem_wd),
        .mem_rd       (mem_rd)
    );

    logic [31:0] mem [0:15];
    assign mem_rd = mem[mem_a[5:2]];
    always @(posedge clk) if (mem_we) mem[mem_a[5:2]] <= mem_wd;

    typedef struct {
        logic        valid;
        logic        err;
        logic [31:0] rdata;
        logic        ready;
        logic        we;
        logic [31:0] wd;
        logic [31:0] a;
    } exp_t;

    exp_t        expq[$];
    logic [31:0] ref_mem [0:15];
    logic [31:0] hold_rdata = '0;
    logic        hold_err = 1'b0;
    logic [31:0] hold_a = '0;
    bit          checking = 1'b0;
    int          errors = 0;
    int          checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the schedule the model queued at accept time.
    exp_t ce;
    always @(negedge clk) begin
        if (rst_n && checking) begin
            if (expq.size() > 0) begin
                ce = expq.pop_front();
            end else begin
                ce.valid = 1'b0; ce.err = hold_err; ce.rdata = hold_rdata;
                ce.ready = 1'b1; ce.we = 1'b0; ce.wd = '0; ce.a = hold_a;
            end
            check("req_ready", req_ready, ce.ready);
            check("rsp_valid", rsp_valid, ce.valid);
            check("rsp_err", rsp_err, ce.err);
            check("rsp_rdata", rsp_rdata, ce.rdata);
            check("mem_we", mem_we, ce.we);
            check("mem_a", mem_a, ce.a);
            if (ce.we) check("mem_wd", mem_wd, ce.wd);
        end
    end

    task automatic model(input logic wr, input logic [1:0] sz, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wd,
                         output logic [31:0] exp_rd, output logic exp_err, output logic [31:0] new_word);
        logic [31:0] word, raw, mask;
        int sh;
        word = ref_mem[addr[5:2]];
        sh = 8 * int'(addr[1:0]);
        exp_err = (sz == 2'd3) || (sz == 2'd1 && addr[0]) || (sz == 2'd2 && addr[1:0] != 2'd0);
        exp_rd = '0;
        raw = word >> sh;
        mask = (sz == 2'd0) ? 32'h0000_00FF : (sz == 2'd1) ? 32'h0000_FFFF : 32'hFFFF_FFFF;
        if (!exp_err && !wr) begin
            exp_rd = raw & mask;
            if (!uns && sz == 2'd0 && exp_rd[7])  exp_rd = exp_rd | 32'hFFFF_FF00;
            if (!uns && sz == 2'd1 && exp_rd[15]) exp_rd = exp_rd | 32'hFFFF_0000;
        end
        mask = mask << sh;
        new_word = (word & ~mask) | ((wd << sh) & mask);
    endtask

    task automatic drive_and_accept(input logic wr, input logic [1:0] sz, input logic uns,
                                    input logic [31:0] addr, input logic [31:0] wd, output bit ok);
        int n = 0;
        @(negedge clk);
        req_write = wr; req_size = sz; req_unsigned = uns;
        req_addr = addr; req_wdata = wd; req_valid = 1'b1;
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        ok = req_ready;
        if (!ok) begin
            errors++; checks++;
            $display("FAIL accept_timeout: req_ready stuck at %b want 1", req_ready);
            req_valid = 1'b0;
            return;
        end
        @(posedge clk);
    endtask

    task automatic issue(input logic wr, input logic [1:0] sz, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wd, input bit keep,
                         output logic [31:0] exp_rd, output logic exp_err);
        logic [31:0] nw, al;
        exp_t b, r, w;
        bit ok;
        int n = 0;
        model(wr, sz, uns, addr, wd, exp_rd, exp_err, nw);
        drive_and_accept(wr, sz, uns, addr, wd, ok);
        if (!ok) return;
        al = {addr[31:2], 2'b00};
        b.valid = 1'b0; b.err = hold_err; b.rdata = hold_rdata;
        b.ready = 1'b0; b.we = 1'b0; b.wd = '0; b.a = al;
        w = b; w.we = 1'b1; w.wd = nw;
        r = b; r.valid = 1'b1; r.err = exp_err; r.rdata = exp_rd;
        if (exp_err) begin
            expq.push_back(r);
        end else if (!wr) begin
            expq.push_back(b); expq.push_back(r);
        end else if (sz == 2'd2) begin
            expq.push_back(w); expq.push_back(r);
        end else begin
            expq.push_back(b); expq.push_back(w); expq.push_back(r);
        end
        hold_rdata = exp_rd; hold_err = exp_err; hold_a = al;
        if (!exp_err && wr) ref_mem[addr[5:2]] = nw;
        #1;
        if (!keep) begin
            req_valid = 1'b0;
            while (expq.size() > 0 && n < 20) begin
                @(negedge clk);
                n++;
            end
        end
    endtask

    logic [31:0] r;
    logic        e;
    bit          ok;

    initial begin
        for (int i = 0; i < 16; i++) ref_mem[i] = '0;
        #12;
        check("reset_req_ready", req_ready, 1);
        check("reset_rsp_valid", rsp_valid, 0);
        check("reset_rsp_err", rsp_err, 0);
        check("reset_rsp_rdata", rsp_rdata, 0);
        check("reset_mem_we", mem_we, 0);
        check("reset_mem_a", mem_a, 0);
        check("reset_mem_wd", mem_wd, 0);
        rst_n = 1'b1;
        checking = 1'b1;

        issue(1, 2'd2, 0, 32'h4, 32'h1122_3344, 0, r, e);
        issue(1, 2'd2, 0, 32'h8, 32'hCAFE_F00D, 0, r, e);
        issue(1, 2'd2, 0, 32'hC, 32'h0000_0000, 0, r, e);

        issue(1, 2'd2, 0, 32'h0, 32'h0000_000F, 0, r, e);
        issue(0, 2'd2, 0, 32'h0, 32'h0, 0, r, e);
        check("lit_word_load", r, 32'h0000_000F);
        check("lit_word_load_err", e, 0);

        issue(1, 2'd0, 0, 32'h5, 32'h0000_00AB, 0, r, e);
        check("lit_byte_rmw_mem", mem[1], 32'h1122_AB44);

        issue(1, 2'd1, 0, 32'hA, 32'h5555_1234, 0, r, e);
        issue(0, 2'd1, 0, 32'hA, 32'h0, 0, r, e);
        check("lit_half_upper", r, 32'h0000_1234);
        for (int i = 0; i < 4; i++) issue(1, 2'd0, 0, 32'hC + i, 32'hEE00_0010 + i, 0, r, e);
        issue(0, 2'd2, 0, 32'hC, 32'h0, 0, r, e);
        check("lit_byte_lanes", r, 32'h1312_1110);

        issue(1, 2'd2, 0, 32'h4, 32'h80FF_7F00, 0, r, e);
        issue(0, 2'd0, 0, 32'h6, 32'h0, 0, r, e);
        check("lit_sb6", r, 32'hFFFF_FFFF);
        issue(0, 2'd0, 1, 32'h6, 32'h0, 0, r, e);
        check("lit_ub6", r, 32'h0000_00FF);
        issue(0, 2'd0, 0, 32'h5, 32'h0, 0, r, e);
        check("lit_sb5", r, 32'h0000_007F);
        issue(0, 2'd1, 0, 32'h6, 32'h0, 0, r, e);
        check("lit_sh6", r, 32'hFFFF_80FF);
        issue(0, 2'd1, 1, 32'h6, 32'h0, 0, r, e);
        check("lit_uh6", r, 32'h0000_80FF);

        issue(0, 2'd2, 0, 32'h2, 32'h0, 0, r, e);
        check("lit_err_word", e, 1);
        issue(1, 2'd1, 0, 32'h3, 32'hFFFF_FFFF, 0, r, e);
        check("lit_err_half", e, 1);
        issue(0, 2'd3, 0, 32'h0, 32'h0, 0, r, e);
        check("lit_err_size", e, 1);
        check("lit_err_rdata", r, 0);
        check("lit_err_mem1", mem[1], 32'h80FF_7F00);

        issue(1, 2'd2, 0, 32'h4, 32'h1122_3344, 0, r, e);
        begin
            logic [31:0] nw, xr;
            logic        xe;
            exp_t b;
            model(1, 2'd1, 0, 32'h4, 32'h0000_BEEF, xr, xe, nw);
            drive_and_accept(1, 2'd1, 0, 32'h4, 32'h0000_BEEF, ok);
            if (ok) begin
                b.valid = 1'b0; b.err = hold_err; b.rdata = hold_rdata;
                b.ready = 1'b0; b.we = 1'b0; b.wd = '0; b.a = 32'h4;
                expq.push_back(b);
                b.we = 1'b1; b.wd = nw;
                expq.push_back(b);
                #1 req_valid = 1'b0;
                @(negedge clk);
                @(negedge clk);
                #2 rst_n = 1'b0;
                #1;
                check("rst_mem_we_async", mem_we, 0);
                check("rst_req_ready", req_ready, 1);
                check("rst_rsp_valid", rsp_valid, 0);
                expq.delete();
                hold_rdata = '0; hold_err = 1'b0; hold_a = '0;
                #1 rst_n = 1'b1;
            end
        end
        repeat (3) @(negedge clk);
        check("lit_rst_mem1", mem[1], 32'h1122_3344);

        issue(0, 2'd2, 0, 32'h0, 32'h0, 1, r, e);
        check("lit_b2b_first", r, 32'h0000_000F);
        issue(0, 2'd2, 0, 32'h4, 32'h0, 0, r, e);
        check("lit_b2b_second", r, 32'h1122_3344);

        repeat (3) @(negedge clk);
        for (int i = 0; i < 4; i++) check("final_mem", mem[i], ref_mem[i]);

        checking = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation time %0t exceeded", $time);
        $fatal(1);
    end

endmodule
